vram_arbiter: RTL

- Shares one single-port video RAM between the CPU bus interface (read/write) and the VGA display fetcher (read-only).
- Sits between busint's vram_cpu_* port, vga_display's vram_vga_* port and the VRAM macro.
- VGA has priority; a starvation counter guarantees the CPU bounded latency.
- One clock domain; any clock crossing is handled outside this block.

---
 rtl/vram_arbiter_if.sv | 44 ++++
 rtl/vram_arbiter.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/vram_arbiter_if.sv
// Bus bundle shared by the VRAM arbiter: CPU request port, VGA fetch port
// and the single-port VRAM macro port. The arbiter uses the slave view;
// the master view belongs to whatever drives requests and models memory.
interface vram_arbiter_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 32
);
    logic              cpu_req;
    logic              cpu_write;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_ready;
    logic              cpu_done;

    logic              vga_req;
    logic [ADDR_W-1:0] vga_addr;
    logic [DATA_W-1:0] vga_rdata;
    logic              vga_ready;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_write, cpu_addr, cpu_wdata,
        input  vga_req, vga_addr,
        input  mem_rdata,
        output cpu_rdata, cpu_ready, cpu_done,
        output vga_rdata, vga_ready,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output cpu_req, cpu_write, cpu_addr, cpu_wdata,
        output vga_req, vga_addr,
        output mem_rdata,
        input  cpu_rdata, cpu_ready, cpu_done,
        input  vga_rdata, vga_ready,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter between the CPU bus port and the VGA fetcher.
// VGA wins ties unless the CPU has watched STARVE_LIMIT consecutive VGA
// grants, which bounds CPU latency. All outputs are registered.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | no access in flight; arbitrate cpu_req / vga_req each edge
// VGA_RD   | VGA read issued; wait latency, pulse vga_ready, then IDLE
// CPU_RD   | CPU read issued; wait latency, capture data, go to CPU_WAIT
// CPU_WR   | CPU write issue cycle; cpu_done follows, go to CPU_WAIT
// CPU_WAIT | access complete; hold until cpu_req is seen low
module vram_arbiter #(
    parameter int ADDR_W       = 15,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    vram_arbiter_if.slave   bus
);
    typedef enum logic [2:0] {IDLE, VGA_RD, CPU_RD, CPU_WR, CPU_WAIT} state_t;

    localparam logic [2:0] LAT_LOAD   = 3'(READ_LATENCY);
    localparam logic [3:0] STREAK_MAX = 4'(STARVE_LIMIT);

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [3:0]        streak_q, streak_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] vga_rdata_q, vga_rdata_d;
    logic              cpu_done_q, cpu_done_d;
    logic              vga_ready_q, vga_ready_d;
    logic              cpu_ready_q, cpu_ready_d;

    // Next-state, arbitration and registered-output preparation.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        streak_d    = streak_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        vga_rdata_d = vga_rdata_q;
        cpu_done_d  = 1'b0;
        vga_ready_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.cpu_req && (!bus.vga_req || streak_q == STREAK_MAX)) begin
                    state_d    = bus.cpu_write ? CPU_WR : CPU_RD;
                    mem_en_d   = 1'b1;
                    mem_we_d   = bus.cpu_write;
                    mem_addr_d = bus.cpu_addr;
                    if (bus.cpu_write) begin
                        mem_wdata_d = bus.cpu_wdata;
                    end
                    cnt_d    = LAT_LOAD;
                    streak_d = 4'd0;
                end else if (bus.vga_req) begin
                    state_d    = VGA_RD;
                    mem_en_d   = 1'b1;
                    mem_addr_d = bus.vga_addr;
                    cnt_d      = LAT_LOAD;
                    if (!bus.cpu_req) begin
                        streak_d = 4'd0;
                    end else if (streak_q != STREAK_MAX) begin
                        streak_d = streak_q + 4'd1;
                    end
                end else begin
                    streak_d = 4'd0;
                end
            end
            VGA_RD: begin
                // vga_ready_q marks the pulse cycle; requests are ignored here.
                if (vga_ready_q) begin
                    state_d = IDLE;
                end else if (cnt_q == 3'd0) begin
                    vga_rdata_d = bus.mem_rdata;
                    vga_ready_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            CPU_RD: begin
                if (cnt_q == 3'd0) begin
                    cpu_rdata_d = bus.mem_rdata;
                    cpu_done_d  = 1'b1;
                    state_d     = CPU_WAIT;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            CPU_WR: begin
                cpu_done_d = 1'b1;
                state_d    = CPU_WAIT;
            end
            CPU_WAIT: begin
                if (!bus.cpu_req) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        cpu_ready_d = (state_d == IDLE) || (state_d == VGA_RD);
    end

    // State and output registers; reset discards any in-flight read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            streak_q    <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_rdata_q <= '0;
            vga_rdata_q <= '0;
            cpu_done_q  <= 1'b0;
            vga_ready_q <= 1'b0;
            cpu_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            streak_q    <= streak_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            vga_rdata_q <= vga_rdata_d;
            cpu_done_q  <= cpu_done_d;
            vga_ready_q <= vga_ready_d;
            cpu_ready_q <= cpu_ready_d;
        end
    end

    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.vga_rdata = vga_rdata_q;
    assign bus.cpu_done  = cpu_done_q;
    assign bus.vga_ready = vga_ready_q;
    assign bus.cpu_ready = cpu_ready_q;
endmodule
